g07_bus_arbiter: RTL

- Central bus controller for the 7-master / 8-slave shared 64-bit bus.
- Grants the bus to one requesting master at a time, with round-robin fairness.
- Decodes the granted master's address to select one slave, sequences the transfer, and returns slave read data and a completion strobe to the master.
- Sits between the master-side (Mstr) and slave-side (Slave) views of g07_if; one instance per bus.

---
 rtl/g07_arb_pkg.sv | 29 ++
 rtl/g07_rr_picker.sv | 33 +++
 rtl/g07_bus_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/g07_arb_pkg.sv
// Shared constants, state type and index helper for the 7-master / 8-slave bus arbiter.
package g07_arb_pkg;

    localparam int NUM_M     = 7;
    localparam int NUM_S     = 8;
    localparam int SEL_W     = 3;
    localparam int DATA_W    = 64;
    localparam int IDX_W     = 3;
    localparam int TIMEOUT_W = $clog2(16 + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // (base + off) mod NUM_M for base, off < NUM_M; one subtraction covers the wrap.
    function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W-1:0] off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IDX_W+1)'(NUM_M)) begin
            sum = sum - (IDX_W+1)'(NUM_M);
        end
        return sum[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/g07_rr_picker.sv
// Rotating-priority request picker: first set request at or above ptr, wrapping at NUM_M-1.
module g07_rr_picker
    import g07_arb_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand_idx [NUM_M];
    logic [NUM_M-1:0] cand_req;

    // Candidate gi is the master gi places after ptr in the rotated order.
    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_cand
            assign cand_idx[gi] = rr_wrap(ptr, IDX_W'(gi));
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest rotated position wins; scanning downward lets the last hit stand.
    always_comb begin
        valid = |cand_req;
        idx   = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                idx = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/g07_bus_arbiter.sv
// Central bus controller: round-robin grant, slave decode, transfer sequencing, timeout.
// Every output is a register that changes together with the state, so each output
// is visible during the state it belongs to (ack in GRANT..DONE, en in XFER, strobes in DONE).
module g07_bus_arbiter
    import g07_arb_pkg::*;
#(
    parameter int SEL_LSB = 61,
    parameter int TIMEOUT = 16
) (
    input  logic                    sysClk,
    input  logic                    Breset,
    input  logic [NUM_M-1:0]        need,
    output logic [NUM_M-1:0]        ack,
    input  logic [NUM_M*DATA_W-1:0] addrM64,
    input  logic [NUM_M*DATA_W-1:0] DoutM,
    output logic [DATA_W-1:0]       MinData,
    output logic [NUM_M-1:0]        Tdone_mstr,
    output logic [DATA_W-1:0]       addr,
    output logic [DATA_W-1:0]       SbusIn,
    output logic [NUM_S-1:0]        en,
    input  logic [NUM_S*DATA_W-1:0] dbus_out,
    input  logic [NUM_S-1:0]        Tdone,
    output logic                    bus_err,
    output logic                    busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_reg;
    logic [IDX_W-1:0]  gnt_idx_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              timeout_hit;
    logic [NUM_M-1:0]  ack_reg;
    logic [NUM_M-1:0]  tdm_reg;
    logic [NUM_S-1:0]  en_reg;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] sbus_reg;
    logic [DATA_W-1:0] min_reg;
    logic              err_reg;
    logic              busy_reg;

    logic [DATA_W-1:0] addr_m  [NUM_M];
    logic [DATA_W-1:0] dout_m  [NUM_M];
    logic [DATA_W-1:0] rdata_s [NUM_S];
    logic [DATA_W-1:0] grant_addr;
    logic [SEL_W-1:0]  grant_sel;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    // Split the flat per-master and per-slave buses into word arrays.
    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_mstr
            assign addr_m[gi] = addrM64[gi*DATA_W +: DATA_W];
            assign dout_m[gi] = DoutM[gi*DATA_W +: DATA_W];
        end
        for (genvar gi = 0; gi < NUM_S; gi++) begin : g_slv
            assign rdata_s[gi] = dbus_out[gi*DATA_W +: DATA_W];
        end
    endgenerate

    g07_rr_picker u_picker (
        .req   (need),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign grant_addr  = addr_m[gnt_idx_reg];
    assign grant_sel   = grant_addr[SEL_LSB +: SEL_W];
    assign cnt_next    = cnt_reg + CNT_W'(1);
    assign timeout_hit = (cnt_next == CNT_W'(TIMEOUT));

    assign ack        = ack_reg;
    assign Tdone_mstr = tdm_reg;
    assign en         = en_reg;
    assign addr       = addr_reg;
    assign SbusIn     = sbus_reg;
    assign MinData    = min_reg;
    assign bus_err    = err_reg;
    assign busy       = busy_reg;

    // Arbitration FSM and all registered outputs; reset aborts any transaction silently.
    always_ff @(posedge sysClk) begin
        if (Breset) begin
            state_reg   <= IDLE;
            gnt_idx_reg <= '0;
            rr_ptr_reg  <= '0;
            sel_reg     <= '0;
            cnt_reg     <= '0;
            ack_reg     <= '0;
            tdm_reg     <= '0;
            en_reg      <= '0;
            addr_reg    <= '0;
            sbus_reg    <= '0;
            min_reg     <= '0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_idx_reg <= pick_idx;
                        ack_reg     <= NUM_M'(1) << pick_idx;
                        busy_reg    <= 1'b1;
                        state_reg   <= GRANT;
                    end
                end
                GRANT: begin
                    addr_reg  <= grant_addr;
                    sbus_reg  <= dout_m[gnt_idx_reg];
                    sel_reg   <= grant_sel;
                    en_reg    <= NUM_S'(1) << grant_sel;
                    cnt_reg   <= '0;
                    state_reg <= XFER;
                end
                XFER: begin
                    // A done in the final allowed cycle still counts as a clean completion.
                    if (Tdone[sel_reg]) begin
                        min_reg   <= rdata_s[sel_reg];
                        en_reg    <= '0;
                        tdm_reg   <= ack_reg;
                        state_reg <= DONE;
                    end else if (timeout_hit) begin
                        min_reg   <= '1;
                        err_reg   <= 1'b1;
                        en_reg    <= '0;
                        tdm_reg   <= ack_reg;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                DONE: begin
                    tdm_reg    <= '0;
                    err_reg    <= 1'b0;
                    ack_reg    <= '0;
                    busy_reg   <= 1'b0;
                    cnt_reg    <= '0;
                    rr_ptr_reg <= rr_wrap(gnt_idx_reg, IDX_W'(1));
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
